// File: rtl/generation_controller_pkg.sv
// Shared types and constants for the Conway generation controller.
package generation_controller_pkg;

    // Controller states; the values are also the STATE debug encoding.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_COMMIT = 3'd4,
        ST_HALTED = 3'd5
    } gen_state_e;

    // The grid calculator needs at least one cycle after LOAD_RUN rises.
    localparam int CALC_LATENCY_MIN = 1;

    // Debug encoding of a state for the STATE port.
    function automatic logic [2:0] state_code(gen_state_e s);
        return 3'(s);
    endfunction

endpackage

// File: rtl/generation_controller_step_timer.sv
// Loadable down-counter shared by the WAIT and SETTLE phases.
// expire is high while the count sits at 1 (the last cycle of a phase).
module step_timer #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expire
);

    logic [W-1:0] count;

    // Load takes priority; otherwise count down while enabled, never below 0.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)                   count <= '0;
        else if (load)                count <= load_val;
        else if (en && count != '0)   count <= count - 1'b1;
    end

    assign expire = (count == W'(1));

endmodule

// File: rtl/generation_controller.sv
// Sequences the Conway system memory through load and run modes.
// Optional feature macro: GENCTRL_STABLE_HALT_EN (halt when the next grid
// equals the current one).
module generation_controller
    import generation_controller_pkg::*;
#(
    parameter int DATA_SIZE    = 64,
    parameter int PERIOD_WIDTH = 16,
    parameter int GEN_WIDTH    = 16,
    parameter int CALC_LATENCY = 2
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    LOAD_VALID,
    output logic                    LOAD_READY,
    input  logic                    START,
    input  logic                    STOP,
    input  logic                    SINGLE_STEP,
    input  logic [PERIOD_WIDTH-1:0] PERIOD,
    input  logic [GEN_WIDTH-1:0]    GEN_LIMIT,
    output logic                    WRITE_ENABLE,
    output logic                    LOAD_RUN,
    output logic                    BUSY,
    output logic                    DONE,
    output logic [GEN_WIDTH-1:0]    GEN_COUNT,
    output logic [2:0]              STATE
`ifdef GENCTRL_STABLE_HALT_EN
    ,
    input  logic [DATA_SIZE-1:0]    GRID_IN,
    input  logic [DATA_SIZE-1:0]    MEM_OUT,
    output logic                    STABLE
`endif
);

    if (CALC_LATENCY < CALC_LATENCY_MIN || DATA_SIZE < 1) begin : g_param_check
        $error("generation_controller: CALC_LATENCY must be >= 1 and DATA_SIZE >= 1");
    end

    gen_state_e state, state_n;
    logic [PERIOD_WIDTH-1:0] period_eff, tmr_val;
    logic [GEN_WIDTH-1:0] cnt_inc;
    logic tmr_load, tmr_en, tmr_expire;
    logic clr_cnt, inc_cnt, done_n, stop_set, flags_clr, single_set;
    logic stop_flag, single_flag, stable_hit, stable_set;

    assign period_eff = (PERIOD == '0) ? PERIOD_WIDTH'(1) : PERIOD;
    assign cnt_inc    = (&GEN_COUNT) ? GEN_COUNT : GEN_COUNT + 1'b1;

`ifdef GENCTRL_STABLE_HALT_EN
    assign stable_hit = (GRID_IN == MEM_OUT);
`else
    assign stable_hit = 1'b0;
`endif

    step_timer #(.W(PERIOD_WIDTH)) u_timer (
        .CLK      (CLK),
        .RESET    (RESET),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .expire   (tmr_expire)
    );

    // State register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= ST_IDLE;
        else        state <= state_n;
    end

    // Next-state and per-cycle control decode.
    always_comb begin
        state_n    = state;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        tmr_en     = 1'b0;
        clr_cnt    = 1'b0;
        inc_cnt    = 1'b0;
        done_n     = 1'b0;
        stop_set   = 1'b0;
        flags_clr  = 1'b0;
        single_set = 1'b0;
        stable_set = 1'b0;
        case (state)
            ST_IDLE, ST_HALTED: begin
                if (LOAD_VALID) begin
                    state_n   = ST_ARMED;
                    clr_cnt   = 1'b1;
                    flags_clr = 1'b1;
                end else if (state == ST_HALTED && STOP) begin
                    state_n = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (LOAD_VALID) begin
                    clr_cnt   = 1'b1;
                    flags_clr = 1'b1;
                end else if (STOP) begin
                    state_n = ST_ARMED;
                end else if (START) begin
                    state_n  = ST_WAIT;
                    tmr_load = 1'b1;
                    tmr_val  = period_eff;
                end else if (SINGLE_STEP) begin
                    state_n    = ST_SETTLE;
                    single_set = 1'b1;
                    tmr_load   = 1'b1;
                    tmr_val    = PERIOD_WIDTH'(CALC_LATENCY);
                end
            end
            ST_WAIT: begin
                if (STOP) begin
                    state_n = ST_ARMED;
                end else if (tmr_expire) begin
                    state_n  = ST_SETTLE;
                    tmr_load = 1'b1;
                    tmr_val  = PERIOD_WIDTH'(CALC_LATENCY);
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_SETTLE: begin
                // A pause request is deferred so the generation is never torn.
                stop_set = STOP;
                if (tmr_expire) state_n = ST_COMMIT;
                else            tmr_en  = 1'b1;
            end
            ST_COMMIT: begin
                inc_cnt   = 1'b1;
                flags_clr = 1'b1;
                if (stable_hit) begin
                    state_n    = ST_HALTED;
                    done_n     = 1'b1;
                    stable_set = 1'b1;
                end else if (GEN_LIMIT != '0 && cnt_inc == GEN_LIMIT) begin
                    state_n = ST_HALTED;
                    done_n  = 1'b1;
                end else if (single_flag || stop_flag) begin
                    state_n = ST_ARMED;
                end else begin
                    state_n  = ST_WAIT;
                    tmr_load = 1'b1;
                    tmr_val  = period_eff;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Generation count, done pulse and pause/single-step flags.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            GEN_COUNT   <= '0;
            DONE        <= 1'b0;
            stop_flag   <= 1'b0;
            single_flag <= 1'b0;
        end else begin
            DONE <= done_n;
            if (clr_cnt)      GEN_COUNT <= '0;
            else if (inc_cnt) GEN_COUNT <= cnt_inc;
            if (flags_clr) begin
                stop_flag   <= 1'b0;
                single_flag <= 1'b0;
            end else begin
                if (stop_set)   stop_flag   <= 1'b1;
                if (single_set) single_flag <= 1'b1;
            end
        end
    end

`ifdef GENCTRL_STABLE_HALT_EN
    // STABLE latches on a stable-grid halt and clears on the next load.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)          STABLE <= 1'b0;
        else if (clr_cnt)    STABLE <= 1'b0;
        else if (stable_set) STABLE <= 1'b1;
    end
`else
    logic unused_stable;
    assign unused_stable = stable_set;
`endif

    assign LOAD_READY   = (state == ST_IDLE) || (state == ST_ARMED) || (state == ST_HALTED);
    assign LOAD_RUN     = (state == ST_WAIT) || (state == ST_SETTLE) || (state == ST_COMMIT);
    assign BUSY         = LOAD_RUN;
    assign WRITE_ENABLE = (LOAD_READY & LOAD_VALID) | (state == ST_COMMIT);
    assign STATE        = state_code(state);

endmodule

// File: tb/tb_generation_controller.sv
// Scoreboard bench for generation_controller: every expected memory write
// (cycle, LOAD_RUN, GEN_COUNT) is queued when stimulus is driven and checked
// when WRITE_ENABLE is observed.
module tb_generation_controller;

    localparam int DW = 64, PW = 16, GW = 16, LAT = 2;

    logic          CLK, RESET, LOAD_VALID, LOAD_READY, START, STOP, SINGLE_STEP;
    logic [PW-1:0] PERIOD;
    logic [GW-1:0] GEN_LIMIT, GEN_COUNT;
    logic          WRITE_ENABLE, LOAD_RUN, BUSY, DONE;
    logic [2:0]    STATE;
`ifdef GENCTRL_STABLE_HALT_EN
    logic [DW-1:0] GRID_IN, MEM_OUT;
    logic          STABLE;
`endif

    generation_controller #(
        .DATA_SIZE(DW), .PERIOD_WIDTH(PW), .GEN_WIDTH(GW), .CALC_LATENCY(LAT)
    ) dut (
        .CLK(CLK), .RESET(RESET), .LOAD_VALID(LOAD_VALID), .LOAD_READY(LOAD_READY),
        .START(START), .STOP(STOP), .SINGLE_STEP(SINGLE_STEP), .PERIOD(PERIOD),
        .GEN_LIMIT(GEN_LIMIT), .WRITE_ENABLE(WRITE_ENABLE), .LOAD_RUN(LOAD_RUN),
        .BUSY(BUSY), .DONE(DONE), .GEN_COUNT(GEN_COUNT), .STATE(STATE)
`ifdef GENCTRL_STABLE_HALT_EN
        , .GRID_IN(GRID_IN), .MEM_OUT(MEM_OUT), .STABLE(STABLE)
`endif
    );

    typedef struct { int cyc; int lr; int gc; } wr_t;
    wr_t sb[$];
    int  cyc = 0;
    int  n_chk = 0, n_pass = 0;
    int  k;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic push(input int c, input int lr, input int gc);
        wr_t e;
        e.cyc = c; e.lr = lr; e.gc = gc;
        sb.push_back(e);
    endtask

    // Memory-write monitor: every write must match the next queued expectation.
    always @(negedge CLK) begin
        if (RESET && WRITE_ENABLE) begin
            if (sb.size() == 0) begin
                chk("unexpected_write_cycle", cyc, -1);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("write_cycle", cyc, e.cyc);
                chk("write_load_run", int'(LOAD_RUN), e.lr);
                chk("write_gen_count", int'(GEN_COUNT), e.gc);
            end
        end
    end

    initial begin
        RESET = 1'b0; LOAD_VALID = 1'b0; START = 1'b0; STOP = 1'b0; SINGLE_STEP = 1'b0;
        PERIOD = 16'd3; GEN_LIMIT = '0;
`ifdef GENCTRL_STABLE_HALT_EN
        GRID_IN = 64'h1; MEM_OUT = 64'h0;
`endif
        // Reset values
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_state", int'(STATE), 0);
        chk("rst_load_ready", int'(LOAD_READY), 1);
        chk("rst_we", int'(WRITE_ENABLE), 0);
        chk("rst_load_run", int'(LOAD_RUN), 0);
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_done", int'(DONE), 0);
        chk("rst_gen_count", int'(GEN_COUNT), 0);
        tick();
        RESET = 1'b1;

        // Load handshake: write with LOAD_RUN=0 this cycle, then ARMED
        tick(); k = cyc;
        LOAD_VALID = 1'b1; push(k, 0, 0);
        tick(); LOAD_VALID = 1'b0;
        @(negedge CLK);
        chk("load_state", int'(STATE), 1);
        chk("load_gen_count", int'(GEN_COUNT), 0);

        // Free run PERIOD=3: commits every 6 cycles, then STOP in WAIT
        tick(); k = cyc;
        START = 1'b1;
        for (int n = 1; n <= 3; n++) push(k + n * 6, 1, n - 1);
        tick(); START = 1'b0;
        wait_to(k + 19);
        STOP = 1'b1;
        tick(); STOP = 1'b0;
        @(negedge CLK);
        chk("stop_wait_state", int'(STATE), 1);
        chk("stop_wait_count", int'(GEN_COUNT), 3);

        // STOP in first SETTLE cycle: generation completes, then ARMED
        tick(); k = cyc;
        START = 1'b1; push(k + 6, 1, 3);
        tick(); START = 1'b0;
        wait_to(k + 4);
        STOP = 1'b1;
        tick(); STOP = 1'b0;
        wait_to(k + 7);
        @(negedge CLK);
        chk("stop_settle_state", int'(STATE), 1);
        chk("stop_settle_count", int'(GEN_COUNT), 4);

        // Single step: one write after LAT settle cycles, back to ARMED
        tick(); k = cyc;
        SINGLE_STEP = 1'b1; push(k + 1 + LAT, 1, 4);
        tick(); SINGLE_STEP = 1'b0;
        wait_to(k + 2 + LAT);
        @(negedge CLK);
        chk("single_state", int'(STATE), 1);
        chk("single_count", int'(GEN_COUNT), 5);

        // PERIOD=0 (WAIT of 1 cycle) with GEN_LIMIT=8: halt after 3 more gens
        tick(); k = cyc;
        PERIOD = '0; GEN_LIMIT = 16'd8; START = 1'b1;
        for (int n = 1; n <= 3; n++) push(k + n * 4, 1, 4 + n);
        tick(); START = 1'b0;
        wait_to(k + 12);
        @(negedge CLK);
        chk("done_before_halt", int'(DONE), 0);
        wait_to(k + 13);
        @(negedge CLK);
        chk("halt_state", int'(STATE), 5);
        chk("halt_done", int'(DONE), 1);
        tick();
        START = 1'b1;
        @(negedge CLK);
        chk("done_one_cycle", int'(DONE), 0);
        tick(); START = 1'b0; SINGLE_STEP = 1'b1;
        tick(); SINGLE_STEP = 1'b0;
        repeat (8) tick();
        @(negedge CLK);
        chk("halt_hold_state", int'(STATE), 5);
        chk("halt_hold_count", int'(GEN_COUNT), 8);

        // STOP in HALTED: back to ARMED keeping the count
        tick(); STOP = 1'b1;
        tick(); STOP = 1'b0;
        @(negedge CLK);
        chk("halt_stop_state", int'(STATE), 1);
        chk("halt_stop_count", int'(GEN_COUNT), 8);

        // Reset asserted during COMMIT drops WRITE_ENABLE immediately
        PERIOD = 16'd3; GEN_LIMIT = '0;
        tick(); k = cyc;
        START = 1'b1; push(k + 6, 1, 8);
        tick(); START = 1'b0;
        wait_to(k + 6);
        @(negedge CLK);
        #1 RESET = 1'b0;
        #1;
        chk("rst_commit_we", int'(WRITE_ENABLE), 0);
        chk("rst_commit_state", int'(STATE), 0);
        chk("rst_commit_count", int'(GEN_COUNT), 0);
        chk("rst_commit_load_run", int'(LOAD_RUN), 0);
        chk("rst_commit_load_ready", int'(LOAD_READY), 1);
        tick(); RESET = 1'b1;

`ifdef GENCTRL_STABLE_HALT_EN
        // Stable grid at COMMIT halts with STABLE and DONE; load clears STABLE
        tick(); k = cyc;
        LOAD_VALID = 1'b1; push(k, 0, 0);
        tick(); LOAD_VALID = 1'b0;
        GRID_IN = 64'hDEAD_BEEF; MEM_OUT = 64'hDEAD_BEEF;
        SINGLE_STEP = 1'b1; push(k + 2 + LAT, 1, 0);
        tick(); SINGLE_STEP = 1'b0;
        wait_to(k + 3 + LAT);
        @(negedge CLK);
        chk("stable_state", int'(STATE), 5);
        chk("stable_flag", int'(STABLE), 1);
        chk("stable_done", int'(DONE), 1);
        tick(); k = cyc;
        LOAD_VALID = 1'b1; push(k, 0, 1);
        tick(); LOAD_VALID = 1'b0;
        @(negedge CLK);
        chk("stable_cleared", int'(STABLE), 0);
`endif

        repeat (3) tick();
        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
